pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush and
// data-memory wait states with a timeout that parks the pipeline in ERR.
module pipe_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           id_rs1,
  input  logic [4:0]           id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [4:0]           ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 dmem_ack,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 memwb_flush,
  output logic                 bus_err,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 bus_err_q, bus_err_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic mem_stall;

  always_comb begin
    load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));
    // A MEM_WAIT stall persists regardless of mem_req; RUN ignores a stray ack.
    mem_stall = ((state_q == RUN) && mem_req && !dmem_ack) ||
                ((state_q == MEM_WAIT) && !dmem_ack);
  end

  // Stage-register control, highest priority first.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path
    // leaves one unassigned, which would infer a latch.
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    if (rst) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == ERR) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      // Freeze PC and IF/ID for one cycle; the load moves on and leaves a bubble.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    bus_err_d   = bus_err_q;
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_d = RUN;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus_err   = bus_err_q;
  assign stall_cnt = stall_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (short timeout / narrow counter, and
// defaults) on shared inputs, checked every cycle against a behavioural model.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, dmem_ack;

  logic       pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a;
  logic       ifid_flush_a, idex_flush_a, memwb_flush_a, bus_err_a;
  logic [3:0] stall_cnt_a;
  logic [1:0] state_a;
  logic       pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b;
  logic       ifid_flush_b, idex_flush_b, memwb_flush_b, bus_err_b;
  logic [15:0] stall_cnt_b;
  logic [1:0] state_b;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(4), .CNT_WIDTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_req(mem_req),
    .dmem_ack(dmem_ack), .pc_en(pc_en_a), .ifid_en(ifid_en_a), .idex_en(idex_en_a),
    .exmem_en(exmem_en_a), .memwb_en(memwb_en_a), .ifid_flush(ifid_flush_a),
    .idex_flush(idex_flush_a), .memwb_flush(memwb_flush_a), .bus_err(bus_err_a),
    .stall_cnt(stall_cnt_a), .state(state_a)
  );

  pipe_ctrl u_dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .mem_req(mem_req),
    .dmem_ack(dmem_ack), .pc_en(pc_en_b), .ifid_en(ifid_en_b), .idex_en(idex_en_b),
    .exmem_en(exmem_en_b), .memwb_en(memwb_en_b), .ifid_flush(ifid_flush_b),
    .idex_flush(idex_flush_b), .memwb_flush(memwb_flush_b), .bus_err(bus_err_b),
    .stall_cnt(stall_cnt_b), .state(state_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Model state per instance: 0 = running, 1 = waiting on memory, 2 = error.
  int m_st[2], m_wait[2], m_cnt[2];
  bit m_err[2];
  int m_tmo[2]  = '{4, 255};
  int m_cmax[2] = '{15, 65535};

  // Expected {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, memwb_fl}.
  function automatic logic [7:0] exp_ctl(input int st);
    bit lu, stall;
    lu    = ex_mem_read && (ex_rd != 0) &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    stall = (st == 0 && mem_req && !dmem_ack) || (st == 1 && !dmem_ack);
    if (rst)         return 8'b01111_111;
    if (st == 2)     return 8'b00000_000;
    if (stall)       return 8'b00001_001;
    if (ex_redirect) return 8'b11111_110;
    if (lu)          return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  function automatic bit model_stall(input int st);
    return (st == 0 && mem_req && !dmem_ack) || (st == 1 && !dmem_ack);
  endfunction

  task automatic model_edge(input int i, input logic [7:0] ctl);
    if (rst) begin
      m_st[i] = 0; m_wait[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
      return;
    end
    if (!ctl[7] && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
    if (m_st[i] == 0) begin
      if (model_stall(0)) begin m_st[i] = 1; m_wait[i] = 0; end
    end else if (m_st[i] == 1) begin
      if (dmem_ack) m_st[i] = 0;
      else if (m_wait[i] + 1 >= m_tmo[i]) begin m_st[i] = 2; m_err[i] = 1; end
      else m_wait[i]++;
    end
  endtask

  // One clock: compare both instances mid-cycle, then advance the model.
  task automatic cycle();
    logic [7:0] ea, eb;
    @(negedge clk);
    ea = exp_ctl(m_st[0]);
    eb = exp_ctl(m_st[1]);
    check("ctl_a", {24'd0, pc_en_a, ifid_en_a, idex_en_a, exmem_en_a, memwb_en_a,
                    ifid_flush_a, idex_flush_a, memwb_flush_a}, {24'd0, ea});
    check("ctl_b", {24'd0, pc_en_b, ifid_en_b, idex_en_b, exmem_en_b, memwb_en_b,
                    ifid_flush_b, idex_flush_b, memwb_flush_b}, {24'd0, eb});
    if (!rst) begin
      check("state_a", {30'd0, state_a}, m_st[0]);
      check("state_b", {30'd0, state_b}, m_st[1]);
      check("bus_err_a", {31'd0, bus_err_a}, {31'd0, m_err[0]});
      check("bus_err_b", {31'd0, bus_err_b}, {31'd0, m_err[1]});
      check("stall_cnt_a", {28'd0, stall_cnt_a}, m_cnt[0]);
      check("stall_cnt_b", {16'd0, stall_cnt_b}, m_cnt[1]);
    end
    @(posedge clk);
    model_edge(0, ea);
    model_edge(1, eb);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0; mem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_use_rs1 = 1'b1; id_rs1 = 5'd5;
  endtask

  initial begin
    idle();
    do_reset(2);
    check("reset_state", {30'd0, state_a}, 32'd0);

    // Load-use on rs1, then the same with x0 as destination.
    set_load_use(5'd5); cycle(); idle(); cycle();
    check("lu_stall_cnt", {16'd0, stall_cnt_b}, 32'd1);
    set_load_use(5'd0); cycle(); idle(); cycle();
    check("lu_x0_stall_cnt", {16'd0, stall_cnt_b}, 32'd1);

    // Three ack-less cycles then an ack.
    do_reset(1);
    mem_req = 1'b1;
    repeat (3) cycle();
    dmem_ack = 1'b1; cycle(); idle(); cycle();
    check("wait_stall_cnt", {16'd0, stall_cnt_b}, 32'd3);

    // Redirect with load-use; redirect held across a two-cycle memory stall.
    ex_redirect = 1'b1; set_load_use(5'd5); cycle(); idle();
    mem_req = 1'b1; ex_redirect = 1'b1;
    repeat (2) cycle();
    dmem_ack = 1'b1; cycle(); idle(); cycle();

    // Timeout on instance A, late ack, then reset recovery.
    do_reset(1);
    mem_req = 1'b1;
    repeat (6) cycle();
    check("timeout_bus_err", {31'd0, bus_err_a}, 32'd1);
    dmem_ack = 1'b1; repeat (2) cycle();
    check("late_ack_state", {30'd0, state_a}, 32'd2);
    idle(); do_reset(1); cycle();
    check("recover_state", {30'd0, state_a}, 32'd0);

    // Saturation: 20 consecutive load-use stalls.
    do_reset(1);
    set_load_use(5'd5);
    repeat (20) cycle();
    check("sat_stall_cnt", {28'd0, stall_cnt_a}, 32'd15);
    idle(); cycle();

    // Random traffic with small register indices so matches are common.
    repeat (2000) begin
      rst         = ($urandom_range(0, 99) < 2);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_redirect = ($urandom_range(0, 99) < 25);
      mem_req     = ($urandom_range(0, 99) < 40);
      dmem_ack    = ($urandom_range(0, 99) < 35);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
